// File: rtl/capture_picture_pkg.sv
// Shared constants for the capture_picture slice: camera geometry, luma
// coefficients, datapath widths and FSM state codes. The macros are guarded
// so that a project-wide define.v included earlier takes precedence.
`ifndef OV5640_X
`define OV5640_X 1280
`endif
`ifndef OV5640_Y
`define OV5640_Y 720
`endif
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 12
`endif
`ifndef LUMA_KR
`define LUMA_KR 77
`endif
`ifndef LUMA_KG
`define LUMA_KG 150
`endif
`ifndef LUMA_KB
`define LUMA_KB 29
`endif

package capture_picture_pkg;

  localparam int CP_POS_W   = `POSITION_WIDTH;
  localparam int CP_FRAME_X = `OV5640_X;
  localparam int CP_FRAME_Y = `OV5640_Y;

  // Luma coefficients; they sum to 256 so the >>8 result never exceeds 255.
  localparam int CP_COEF_W = 8;
  localparam logic [CP_COEF_W-1:0] CP_KR = CP_COEF_W'(`LUMA_KR);
  localparam logic [CP_COEF_W-1:0] CP_KG = CP_COEF_W'(`LUMA_KG);
  localparam logic [CP_COEF_W-1:0] CP_KB = CP_COEF_W'(`LUMA_KB);

  localparam int CP_CH_W   = 8;
  localparam int CP_PROD_W = 16;
  localparam int CP_SUM_W  = 18;

  typedef logic [1:0] cp_state_t;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

endpackage

// File: rtl/capture_picture_rgb_to_gray.sv
// rgb_to_gray: two-stage luminance + threshold pipeline. The valid flag
// (window/capture qualifier from the top) travels with the pixel data.
module rgb_to_gray
  import capture_picture_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int COEF_W = CP_COEF_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  input  logic [7:0]        i_threshold,
  output logic              o_vld,
  output logic              o_bit
);

  localparam int CH_W = DATA_W / 3;

  // Sum of weighted channels fits in 16 bits (max 255*256), so the upper
  // sum bits are always zero and gray is simply bits [15:8].
  function automatic logic [7:0] f_luma(input logic [CP_SUM_W-1:0] sum);
    return sum[15:8];
  endfunction

  logic [CH_W-1:0]       w_r, w_g, w_b;
  logic [CP_PROD_W-1:0]  r_prod_r_p1, r_prod_g_p1, r_prod_b_p1;
  logic                  r_vld_p1;
  logic [CP_SUM_W-1:0]   w_sum_p1;
  logic [7:0]            w_gray_p1;
  logic                  r_vld_p2;
  logic                  r_bit_p2;

  assign w_r = i_data[3*CH_W-1:2*CH_W];
  assign w_g = i_data[2*CH_W-1:CH_W];
  assign w_b = i_data[CH_W-1:0];

  // ---- stage 1: channel products
  always_ff @(posedge sys_clk) begin
    r_prod_r_p1 <= CP_PROD_W'(w_r) * CP_PROD_W'(CP_KR);
    r_prod_g_p1 <= CP_PROD_W'(w_g) * CP_PROD_W'(CP_KG);
    r_prod_b_p1 <= CP_PROD_W'(w_b) * CP_PROD_W'(CP_KB);
  end

  // Stage-1 valid (control, reset).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_vld_p1 <= 1'b0;
    else            r_vld_p1 <= i_vld;
  end

  assign w_sum_p1  = CP_SUM_W'(r_prod_r_p1) + CP_SUM_W'(r_prod_g_p1) + CP_SUM_W'(r_prod_b_p1);
  assign w_gray_p1 = f_luma(w_sum_p1);

  // ---- stage 2: sum, threshold, register outputs (outputs must read 0 in reset)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vld_p2 <= 1'b0;
      r_bit_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_bit_p2 <= (w_gray_p1 >= i_threshold);
    end
  end

  assign o_vld = r_vld_p2;
  assign o_bit = r_bit_p2;

  logic unused_coef_w;
  assign unused_coef_w = ^COEF_W;

endmodule

// File: rtl/capture_picture.sv
// capture_picture: taps the camera pixel stream, thresholds the luminance of
// a rectangular window and writes it row-major into a 1-bit bitmap RAM.
module capture_picture
  import capture_picture_pkg::*;
#(
  parameter int P_W     = CP_POS_W,
  parameter int FRAME_X = CP_FRAME_X,
  parameter int FRAME_Y = CP_FRAME_Y,
  parameter int REG_X1  = 768,
  parameter int REG_Y1  = 576,
  parameter int REG_W   = 128,
  parameter int REG_H   = 128,
  parameter int ADDR_W  = 14
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_threshold,
  input  logic              i_valid,
  input  logic [23:0]       i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_wr_data
);

  localparam logic [P_W-1:0]    X_LAST = P_W'(FRAME_X - 1);
  localparam logic [P_W-1:0]    Y_LAST = P_W'(FRAME_Y - 1);
  localparam logic [P_W-1:0]    X_LO   = P_W'(REG_X1);
  localparam logic [P_W-1:0]    X_HI   = P_W'(REG_X1 + REG_W);
  localparam logic [P_W-1:0]    Y_LO   = P_W'(REG_Y1);
  localparam logic [P_W-1:0]    Y_HI   = P_W'(REG_Y1 + REG_H);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(REG_W * REG_H - 1);

  cp_state_t         r_state;
  logic [P_W-1:0]    r_cnt_x, r_cnt_y;
  logic [7:0]        r_thr;
  logic [ADDR_W-1:0] r_addr;
  logic              w_sof;
  logic              w_in_win;
  logic              w_take;
  logic              w_wr_en;
  logic              w_wr_bit;

  assign w_sof    = i_valid && (r_cnt_x == '0) && (r_cnt_y == '0);
  assign w_in_win = (r_cnt_x >= X_LO) && (r_cnt_x < X_HI) &&
                    (r_cnt_y >= Y_LO) && (r_cnt_y < Y_HI);
  // The SOF pixel is already part of the capture while still in ARM.
  assign w_take   = i_valid && w_in_win &&
                    (((r_state == S_ARM) && w_sof) || (r_state == S_CAPTURE));

  // Frame position counters, advanced only by valid pixels.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_x <= '0;
      r_cnt_y <= '0;
    end else if (i_valid) begin
      if (r_cnt_x == X_LAST) begin
        r_cnt_x <= '0;
        r_cnt_y <= (r_cnt_y == Y_LAST) ? '0 : r_cnt_y + P_W'(1);
      end else begin
        r_cnt_x <= r_cnt_x + P_W'(1);
      end
    end
  end

  // Capture FSM; the threshold is latched only when a start is accepted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_thr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_ARM;
            r_thr   <= i_threshold;
          end
        end
        S_ARM:     if (w_sof) r_state <= S_CAPTURE;
        S_CAPTURE: if (w_wr_en && (r_addr == A_LAST)) r_state <= S_DONE;
        S_DONE:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Bitmap address: cleared on an accepted start, bumped after every write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                          r_addr <= '0;
    else if ((r_state == S_IDLE) && i_start) r_addr <= '0;
    else if (w_wr_en)                        r_addr <= r_addr + ADDR_W'(1);
  end

  rgb_to_gray #(
    .DATA_W (24),
    .COEF_W (CP_COEF_W)
  ) u_rgb_to_gray (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .i_vld       (w_take),
    .i_data      (i_data),
    .i_threshold (r_thr),
    .o_vld       (w_wr_en),
    .o_bit       (w_wr_bit)
  );

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_wr_en   = w_wr_en;
  assign o_wr_addr = r_addr;
  assign o_wr_data = w_wr_bit;

endmodule

// File: tb/tb_capture_picture.sv
// Self-checking bench for capture_picture on an 8x4 frame with a 4x2 window.
module tb_capture_picture;

  localparam int FX = 8, FY = 4, X1 = 2, Y1 = 1, W = 4, H = 2;
  localparam int NPIX = FX * FY;
  localparam int N = W * H;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  addr;
    logic        d;
  } wr_t;

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_threshold = 8'd0;
  logic        i_valid = 1'b0;
  logic [23:0] i_data = 24'd0;
  logic        o_busy, o_done, o_wr_en, o_wr_data;
  logic [2:0]  o_wr_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t obs_wr[$];
  wr_t exp_wr[$];
  int  obs_done[$];
  int  exp_done[$];
  bit  obs_busy [0:4095];

  // reference model state
  int  m_pix = 0;
  bit  m_pending = 0;
  int  m_cap_frame = 0;
  int  m_thr = 0;
  int  m_k = 0;
  int  m_done_cyc = 0;
  int  m_acc_cyc = 0;

  capture_picture #(
    .FRAME_X (FX), .FRAME_Y (FY),
    .REG_X1 (X1), .REG_Y1 (Y1), .REG_W (W), .REG_H (H),
    .ADDR_W (3)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (sys_rst_n),
    .i_start     (i_start),
    .i_threshold (i_threshold),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_wr_en) obs_wr.push_back('{cyc: 32'(cyc), addr: o_wr_addr, d: o_wr_data});
    if (o_done) obs_done.push_back(cyc);
    obs_busy[cyc % 4096] <= o_busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Behavioural model: whole-frame view. A start accepted while idle selects
  // the next frame whose first pixel arrives strictly later; its in-window
  // pixels become writes 2 cycles later, done follows the last write by 1.
  task automatic model_cycle(input logic st, input logic [7:0] thr, input logic v, input logic [23:0] d);
    int px, py, r, g, b, gray;
    if (m_pending && m_k == N && cyc > m_done_cyc) m_pending = 0;
    if (st && !m_pending) begin
      m_pending = 1; m_thr = thr; m_k = 0; m_acc_cyc = cyc;
      m_cap_frame = v ? (m_pix / NPIX + 1) : ((m_pix + NPIX - 1) / NPIX);
    end
    if (v) begin
      px = m_pix % FX;
      py = (m_pix / FX) % FY;
      if (m_pending && m_k < N && (m_pix / NPIX) == m_cap_frame &&
          px >= X1 && px < X1 + W && py >= Y1 && py < Y1 + H) begin
        r = d[23:16]; g = d[15:8]; b = d[7:0];
        gray = (77 * r + 150 * g + 29 * b) / 256;
        exp_wr.push_back('{cyc: 32'(cyc + 2), addr: 3'(m_k), d: (gray >= m_thr)});
        m_k++;
        if (m_k == N) begin
          m_done_cyc = cyc + 3;
          exp_done.push_back(cyc + 3);
        end
      end
      m_pix++;
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] thr, input logic v, input logic [23:0] d);
    @(posedge clk);
    #1;
    i_start = st; i_threshold = thr; i_valid = v; i_data = d;
    model_cycle(st, thr, v, d);
  endtask

  task automatic drive_px(input int mode, input int gap, inout bit tog, input logic st, input logic [7:0] thr);
    logic v;
    logic [23:0] d;
    int px;
    case (gap)
      0:       v = 1'b1;
      1:       begin v = tog; tog = !tog; end
      default: v = 1'($urandom_range(0, 1));
    endcase
    px = m_pix % FX;
    case (mode)
      0:       d = 24'hFFFFFF;
      1:       d = (px % 2 == 0) ? 24'h808080 : 24'h7F7F7F;
      2:       d = (px % 2 == 0) ? 24'hFF0000 : 24'h4D4D4D;
      default: d = 24'($urandom);
    endcase
    if (!v) d = 24'($urandom);
    drive(st, thr, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 1'b0, 24'd0);
  endtask

  task automatic clear_q();
    obs_wr.delete(); exp_wr.delete(); obs_done.delete(); exp_done.delete();
  endtask

  // Start, then pixels until the model sees the capture complete.
  task automatic run_capture(input logic [7:0] thr, input int mode, input int gap, input bit extra);
    bit tog = 1;
    int guard = 0;
    drive(1'b1, thr, 1'b0, 24'd0);
    while (m_pending && guard < 400) begin
      drive_px(mode, gap, tog, extra && (m_k == 3), 8'd0);
      guard++;
    end
    idle(4);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    checks++; if (o_wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en got %b want 0", o_wr_en); end
    checks++; if (o_wr_addr !== 3'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", o_wr_addr); end
    checks++; if (o_wr_data !== 1'b0) begin errors++; $display("FAIL reset_wr_data got %b want 0", o_wr_data); end
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_full_capture();
    clear_q();
    run_capture(8'd128, 0, 0, 1'b0);
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL full_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL full_wr%0d got c=%0d a=%0d d=%b want c=%0d a=%0d d=%b", i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].d, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].d); end
    end
    checks++; if (obs_done != exp_done) begin errors++; $display("FAIL full_done got %p want %p", obs_done, exp_done); end
    checks++; if (obs_busy[m_acc_cyc % 4096] !== 1'b0) begin errors++; $display("FAIL full_busy_pre got 1 want 0"); end
    checks++; if (obs_busy[(m_acc_cyc + 1) % 4096] !== 1'b1) begin errors++; $display("FAIL full_busy_rise got 0 want 1"); end
    checks++; if (obs_busy[m_done_cyc % 4096] !== 1'b1) begin errors++; $display("FAIL full_busy_at_done got 0 want 1"); end
    checks++; if (obs_busy[(m_done_cyc + 1) % 4096] !== 1'b0) begin errors++; $display("FAIL full_busy_fall got 1 want 0"); end
  endtask

  task automatic test_threshold_edge();
    for (int t = 0; t < 2; t++) begin
      clear_q();
      if (t == 0) run_capture(8'd128, 1, 0, 1'b0);
      else        run_capture(8'd77, 2, 0, 1'b0);
      checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL thr%0d_count got %0d want %0d", t, obs_wr.size(), exp_wr.size()); end
      foreach (exp_wr[i]) if (i < obs_wr.size()) begin
        checks++;
        if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL thr%0d_wr%0d got c=%0d a=%0d d=%b want c=%0d a=%0d d=%b", t, i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].d, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].d); end
      end
      checks++; if (obs_done != exp_done) begin errors++; $display("FAIL thr%0d_done got %p want %p", t, obs_done, exp_done); end
    end
  endtask

  task automatic test_start_mid_frame();
    bit tog = 1;
    int guard = 0;
    clear_q();
    while ((m_pix % NPIX) != (2 * FX + 5) && guard < 100) begin
      drive_px(0, 0, tog, 1'b0, 8'd0);
      guard++;
    end
    drive(1'b1, 8'd128, 1'b1, 24'hFFFFFF);
    guard = 0;
    while (m_pending && guard < 400) begin
      drive_px(0, 0, tog, 1'b0, 8'd0);
      guard++;
    end
    idle(4);
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL mid_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL mid_wr%0d got c=%0d a=%0d d=%b want c=%0d a=%0d d=%b", i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].d, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].d); end
    end
    checks++; if (obs_done != exp_done) begin errors++; $display("FAIL mid_done got %p want %p", obs_done, exp_done); end
  endtask

  task automatic test_gapped();
    clear_q();
    run_capture(8'd128, 3, 1, 1'b0);
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL gap_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL gap_wr%0d got c=%0d a=%0d d=%b want c=%0d a=%0d d=%b", i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].d, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].d); end
    end
    checks++; if (obs_done != exp_done) begin errors++; $display("FAIL gap_done got %p want %p", obs_done, exp_done); end
  endtask

  task automatic test_start_while_busy();
    clear_q();
    run_capture(8'd128, 1, 0, 1'b1);
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL busy_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL busy_wr%0d got c=%0d a=%0d d=%b want c=%0d a=%0d d=%b", i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].d, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].d); end
    end
    checks++; if (obs_done.size() != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", obs_done.size()); end
  endtask

  task automatic test_reset_mid_capture();
    bit tog = 1;
    int guard = 0;
    clear_q();
    drive(1'b1, 8'd128, 1'b0, 24'd0);
    while (obs_wr.size() < 3 && guard < 200) begin
      drive_px(1, 0, tog, 1'b0, 8'd0);
      guard++;
    end
    checks++; if (obs_wr.size() < 3) begin errors++; $display("FAIL rst_wait got %0d writes want 3", obs_wr.size()); end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_wr_en, o_wr_addr, o_wr_data} !== 7'd0) begin
      errors++; $display("FAIL rst_outputs got busy=%b done=%b en=%b a=%0d d=%b want all 0", o_busy, o_done, o_wr_en, o_wr_addr, o_wr_data);
    end
    for (int i = 0; i < 3 && i < obs_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rst_pre_wr%0d got c=%0d a=%0d d=%b want c=%0d a=%0d d=%b", i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].d, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].d); end
    end
    i_start = 1'b0; i_valid = 1'b0;
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    m_pix = 0; m_pending = 0; m_k = 0;
    idle(6);
    checks++; if (obs_done.size() != 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", obs_done.size()); end
    checks++; if (obs_wr.size() > 4) begin errors++; $display("FAIL rst_no_more_wr got %0d want <=4", obs_wr.size()); end
    clear_q();
    run_capture(8'd128, 0, 0, 1'b0);
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL rst_re_count got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    foreach (exp_wr[i]) if (i < obs_wr.size()) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rst_re_wr%0d got c=%0d a=%0d d=%b want c=%0d a=%0d d=%b", i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].d, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].d); end
    end
    checks++; if (obs_done != exp_done) begin errors++; $display("FAIL rst_re_done got %p want %p", obs_done, exp_done); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      clear_q();
      idle(int'($urandom_range(0, 9)));
      run_capture(8'($urandom_range(0, 255)), 3, 2, 1'($urandom_range(0, 1)));
      checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", it, obs_wr.size(), exp_wr.size()); end
      foreach (exp_wr[i]) if (i < obs_wr.size()) begin
        checks++;
        if (obs_wr[i] !== exp_wr[i]) begin errors++; $display("FAIL rand%0d_wr%0d got c=%0d a=%0d d=%b want c=%0d a=%0d d=%b", it, i, obs_wr[i].cyc, obs_wr[i].addr, obs_wr[i].d, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].d); end
      end
      checks++; if (obs_done != exp_done) begin errors++; $display("FAIL rand%0d_done got %p want %p", it, obs_done, exp_done); end
    end
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_threshold_edge();
    test_start_mid_frame();
    test_gapped();
    test_start_while_busy();
    test_reset_mid_capture();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
